instr_encoder: RTL
==================

Name: instr_encoder

Overview:
Sequential RV32I instruction encoder and program loader. It is the inverse of the core's opcode decoder: it accepts instruction descriptors over a valid/ready stream, packs each into a 32-bit RV32I word using the same opcode set the core controller decodes, and writes the words to consecutive instruction-memory addresses. It sits between the testbench or boot source and the instruction-memory write port, and is used to load programs before the core is released.

Parameters:
IMEM_ADDR_W, 9, instruction-memory word-address width (depth = 2**IMEM_ADDR_W words)
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session (ignored unless IDLE, DONE or ERR)
in_valid  in  1  descriptor valid
in_ready  out  1  encoder accepts descriptor this cycle
in_class  in  4  instruction class (enc_class_t)
in_funct3  in  3  funct3 field
in_funct7b5  in  1  bit 30 (sub/sra select); R-type only
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  signed immediate; for LUI, the full 32-bit value
wr_en  out  1  instruction-memory write strobe
wr_addr  out  IMEM_ADDR_W  word address
wr_data  out  32  encoded instruction
busy  out  1  state == RUN
done  out  1  high in DONE
err  out  1  high in ERR
count  out  IMEM_ADDR_W+1  words written this session

Behaviour:
- Reset: state IDLE. All of the following are 0: in_ready, wr_en, wr_addr, wr_data, busy, done, err, count. The address counter is loaded with BASE_ADDR. Reset mid-session aborts the session and discards any pending write.
- FSM states: IDLE, RUN, DONE, ERR.
  - IDLE/DONE/ERR + start -> RUN. On this transition: address = BASE_ADDR, count = 0, done and err cleared.
  - RUN: in_ready = 1. A descriptor is accepted when in_valid && in_ready.
  - RUN + accepted CLS_HALT -> DONE, after its write is issued.
  - RUN + accepted illegal descriptor -> ERR.
  - RUN + accepted descriptor while count == 2**IMEM_ADDR_W -> ERR (overflow); nothing is written.
- Latency: a descriptor accepted in cycle N produces wr_en = 1 in cycle N+1, with registered wr_addr and wr_data. wr_en is a single-cycle pulse per word. The address increments and count increments in the write cycle. Throughput is one word per cycle.
- Encoding (opcodes identical to the core controller):
  - R: 0110011, funct7 = {0, in_funct7b5, 00000}
  - LOAD: 0000011, I-format
  - STORE: 0100011, S-format
  - BRANCH: 1100011, B-format
  - OPIMM: 0010011, I-format
  - JAL: 1101111, J-format
  - JALR: 1100111, I-format, funct3 forced to 000
  - LUI: 0110111, U-format, in_imm[31:12]
  - HALT: 32'h00000000
  - Fields not used by a format are ignored.
- Legality: any of the following goes to ERR, with no write and err = 1 from the next cycle.
  - I/S immediate outside [-2048, 2047]
  - B immediate outside [-4096, 4094], or bit 0 set
  - J immediate outside [-2^20, 2^20-2], or bit 0 set
  - LUI with in_imm[11:0] != 0
  - undefined class code
- wr_addr wraps only via overflow detection; it never silently wraps.
- Descriptors presented while not in RUN are ignored (in_ready = 0).
- start asserted during RUN is ignored.

Decomposition:
- Package rv_enc_pkg:
  - enc_class_t enum: CLS_R=0, CLS_LOAD=1, CLS_STORE=2, CLS_BRANCH=3, CLS_OPIMM=4, CLS_JAL=5, CLS_JALR=6, CLS_LUI=7, CLS_HALT=8
  - opcode localparams shared with the controller
  - state enum
- One combinational sub-module, instr_pack: inputs are the descriptor, outputs are the 32-bit word and an illegal flag. The top level holds the FSM, the output register, the address counter and count.

Test Plan:
- add x3,x1,x2 (R, funct3 0, b5 0) after start -> wr_en next cycle, wr_addr 0, wr_data 0x002081B3.
- Back-to-back addi x5,x0,-1; sw x2,8(x1) -> consecutive writes 0xFFF00293 @0 and 0x0020A423 @1, one per cycle, count = 2.
- beq x1,x2,-4 then jal x1,8 then HALT -> 0xFE208EE3, 0x008000EF, 0x00000000 at addresses 0..2. After these, done = 1, busy = 0, in_ready = 0.
- addi with imm 2048 -> no wr_en, err = 1, state ERR. A subsequent start -> RUN with count = 0 and address = BASE_ADDR.
- IMEM_ADDR_W = 2, five non-halt descriptors -> four writes at addresses 0..3, fifth accepted -> ERR, no fifth write.
- reset asserted the cycle after acceptance -> no wr_en, all outputs 0, state IDLE.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder: descriptor classes,
// base opcodes (identical to the core controller's decode table) and FSM states.
package rv_enc_pkg;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_LOAD   = 4'd1,
        CLS_STORE  = 4'd2,
        CLS_BRANCH = 4'd3,
        CLS_OPIMM  = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_JALR   = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_HALT   = 4'd8
    } enc_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: turns one instruction descriptor into an RV32I word
// and flags descriptors whose immediate or class cannot be encoded.
module instr_pack
    import rv_enc_pkg::*;
(
    input  logic [3:0]  in_class,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic signed [31:0] imm_s;
    logic               fits_i;
    logic               fits_b;
    logic               fits_j;
    enc_class_t         cls;

    assign imm_s  = in_imm;
    assign cls    = enc_class_t'(in_class);
    assign fits_i = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    // B/J targets are halfword aligned, so the top of range is odd-excluded by the bit-0 test
    assign fits_b = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4095) && !in_imm[0];
    assign fits_j = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048575) && !in_imm[0];

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (cls)
            CLS_R: begin
                word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
            end
            CLS_LOAD: begin
                word    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
                illegal = !fits_i;
            end
            CLS_STORE: begin
                word    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
                illegal = !fits_i;
            end
            CLS_BRANCH: begin
                word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OP_BRANCH};
                illegal = !fits_b;
            end
            CLS_OPIMM: begin
                word    = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_OPIMM};
                illegal = !fits_i;
            end
            CLS_JAL: begin
                word    = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
                illegal = !fits_j;
            end
            CLS_JALR: begin
                word    = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
                illegal = !fits_i;
            end
            CLS_LUI: begin
                word    = {in_imm[31:12], in_rd, OP_LUI};
                illegal = (in_imm[11:0] != 12'd0);
            end
            CLS_HALT: begin
                word = '0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts descriptors while running, writes packed words to
// consecutive instruction-memory addresses one cycle after acceptance.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int IMEM_ADDR_W = 9,
    parameter int BASE_ADDR   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_class,
    input  logic [2:0]             in_funct3,
    input  logic                   in_funct7b5,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [31:0]            in_imm,
    output logic                   wr_en,
    output logic [IMEM_ADDR_W-1:0] wr_addr,
    output logic [31:0]            wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [IMEM_ADDR_W:0]   count
);

    localparam logic [IMEM_ADDR_W:0]   DEPTH     = {1'b1, {IMEM_ADDR_W{1'b0}}};
    localparam logic [IMEM_ADDR_W-1:0] BASE      = IMEM_ADDR_W'(BASE_ADDR);
    localparam logic [IMEM_ADDR_W-1:0] ADDR_ONE  = IMEM_ADDR_W'(1);
    localparam logic [IMEM_ADDR_W:0]   COUNT_ONE = (IMEM_ADDR_W+1)'(1);

    enc_state_t             state;
    logic [IMEM_ADDR_W-1:0] addr;
    logic [31:0]            word;
    logic                   illegal;

    instr_pack u_pack (
        .in_class    (in_class),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .word        (word),
        .illegal     (illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            addr     <= BASE;
            count    <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        addr     <= BASE;
                        count    <= '0;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        // A full memory is checked before legality so nothing lands past the end
                        if (illegal || count == DEPTH) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= word;
                            addr    <= addr + ADDR_ONE;
                            count   <= count + COUNT_ONE;
                            if (in_class == CLS_HALT) begin
                                state    <= ST_DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
